// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780-style command constants and write-sequencer state encoding.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] LCD_ROW1_BASE     = 8'h40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        CLR  = 2'd3
    } state_t;

endpackage

// File: rtl/lcd_write_seq.sv
// lcd_write_seq: turns character/clear requests into LCD command-buffer pushes,
// skipping the DDRAM address byte when the tracked cursor already points there.
module lcd_write_seq
    import lcd_pkg::*;
#(
    parameter int         COLS      = 16,
    parameter logic [7:0] ROW1_BASE = LCD_ROW1_BASE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_clr,
    input  logic       req_row,
    input  logic [3:0] req_col,
    input  logic [7:0] req_char,
    input  logic       buf_full,
    output logic       en,
    output logic       cmd,
    output logic [7:0] data
);

    localparam logic [3:0] COL_MAX  = 4'(COLS - 1);
    localparam logic [4:0] COL_WRAP = 5'(COLS);

    state_t     state;
    logic       row_q;
    logic [3:0] col_q;
    logic [7:0] char_q;
    logic       cur_valid;
    logic       cur_row;
    logic [3:0] cur_col;
    logic       cmd_q;
    logic [7:0] data_q;

    logic [3:0] col_c;
    logic       need_addr;
    logic       push_cmd;
    logic [7:0] push_data;
    logic [4:0] col_next;

    always_comb begin
        col_c     = (req_col > COL_MAX) ? COL_MAX : req_col;
        need_addr = !cur_valid || (req_row != cur_row) || (col_c != cur_col);
        push_cmd  = (state != DATA);
        push_data = (state == CLR)  ? LCD_CMD_CLEAR :
                    (state == ADDR) ? (LCD_CMD_SET_DDRAM | (row_q ? ROW1_BASE : 8'h00) | {4'h0, col_q}) :
                                      char_q;
        col_next  = {1'b0, col_q} + 5'd1;
        req_ready = (state == IDLE);
        // The push strobe follows buf_full in the same cycle so a stall costs no extra latency.
        en        = (state != IDLE) && !buf_full;
        cmd       = en ? push_cmd : cmd_q;
        data      = en ? push_data : data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            row_q     <= 1'b0;
            col_q     <= 4'h0;
            char_q    <= 8'h00;
            cur_valid <= 1'b0;
            cur_row   <= 1'b0;
            cur_col   <= 4'h0;
            cmd_q     <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            if (en) begin
                cmd_q  <= push_cmd;
                data_q <= push_data;
            end
            case (state)
                IDLE: if (req_valid) begin
                    row_q  <= req_row;
                    col_q  <= col_c;
                    char_q <= req_char;
                    state  <= req_clr ? CLR : need_addr ? ADDR : DATA;
                end
                ADDR: if (!buf_full) state <= DATA;
                DATA: if (!buf_full) begin
                    state <= IDLE;
                    // Past the last column the display's own cursor is not trusted; force a re-address.
                    if (col_next == COL_WRAP) begin
                        cur_valid <= 1'b0;
                    end else begin
                        cur_valid <= 1'b1;
                        cur_row   <= row_q;
                        cur_col   <= col_next[3:0];
                    end
                end
                CLR: if (!buf_full) begin
                    state     <= IDLE;
                    cur_valid <= 1'b1;
                    cur_row   <= 1'b0;
                    cur_col   <= 4'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_write_seq.sv
// tb_lcd_write_seq: directed and random requests checked cycle by cycle against
// a push-list model of the LCD write sequencer.
module tb_lcd_write_seq;

    localparam int COLS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_clr = 1'b0;
    logic       req_row = 1'b0;
    logic [3:0] req_col = 4'h0;
    logic [7:0] req_char = 8'h00;
    logic       buf_full = 1'b0;
    logic       req_ready;
    logic       en;
    logic       cmd;
    logic [7:0] data;

    always #5 clk = ~clk;

    lcd_write_seq #(.COLS(COLS), .ROW1_BASE(8'h40)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_clr(req_clr), .req_row(req_row), .req_col(req_col), .req_char(req_char),
        .buf_full(buf_full), .en(en), .cmd(cmd), .data(data)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int base = 0;
    int acc = 0;
    logic [8:0] exp_q[$];
    logic [8:0] obs_log[$];
    int         obs_cyc[$];
    logic [8:0] last = 9'h000;
    bit m_valid = 1'b0;
    bit m_row = 1'b0;
    int m_col = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected pushes for one accepted request, from the cursor-tracking rules.
    function automatic void model_accept(bit clr, bit row, int col, logic [7:0] ch);
        int c;
        c = (col >= COLS) ? COLS - 1 : col;
        if (clr) begin
            exp_q.push_back(9'h101);
            m_valid = 1'b1; m_row = 1'b0; m_col = 0;
        end else begin
            if (!m_valid || row != m_row || c != m_col)
                exp_q.push_back({1'b1, 8'(128 + (row ? 64 : 0) + c)});
            exp_q.push_back({1'b0, ch});
            if (c + 1 == COLS) m_valid = 1'b0;
            else begin m_valid = 1'b1; m_row = row; m_col = c + 1; end
        end
    endfunction

    always @(negedge clk) begin
        bit idle;
        bit exp_en;
        #2;
        cyc++;
        if (!rst) begin
            chk("rst_en", en, 0);
            chk("rst_cmd", cmd, 0);
            chk("rst_data", data, 0);
            exp_q.delete();
            m_valid = 1'b0; m_row = 1'b0; m_col = 0;
            last = 9'h000;
        end else begin
            idle   = (exp_q.size() == 0);
            exp_en = !idle && !buf_full;
            chk("req_ready", req_ready, idle);
            chk("en", en, exp_en);
            if (exp_en) begin
                chk("cmd", cmd, exp_q[0][8]);
                chk("data", data, exp_q[0][7:0]);
                last = exp_q.pop_front();
            end else begin
                chk("hold_cmd", cmd, last[8]);
                chk("hold_data", data, last[7:0]);
            end
            if (en === 1'b1) begin
                obs_log.push_back({cmd, data});
                obs_cyc.push_back(cyc);
            end
            if (idle && req_valid) begin
                acc_cyc = cyc;
                model_accept(req_clr, req_row, int'(req_col), req_char);
            end
        end
    end

    task automatic drive(input bit v, input bit c, input bit r, input logic [3:0] col,
                         input logic [7:0] ch, input bit bf);
        @(negedge clk);
        req_valid = v; req_clr = c; req_row = r; req_col = col; req_char = ch; buf_full = bf;
        #3;
    endtask

    task automatic idle_n(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    endtask

    task automatic wr(input bit c, input bit r, input logic [3:0] col, input logic [7:0] ch);
        base = obs_log.size();
        drive(1'b1, c, r, col, ch, 1'b0);
        acc = acc_cyc;
        idle_n(4);
    endtask

    task automatic expect_push(input string name, input int idx, input logic [8:0] v, input int at);
        checks++;
        if (obs_log.size() <= idx) begin
            errors++;
            $display("FAIL %s: no push seen, required %h at cycle %0d", name, v, at);
        end else if (obs_log[idx] !== v || obs_cyc[idx] != at) begin
            errors++;
            $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                     name, obs_log[idx], obs_cyc[idx], v, at);
        end
    endtask

    initial begin
        idle_n(3);
        @(negedge clk); rst = 1'b1; #3;
        chk("ready_after_rst", req_ready, 1);
        idle_n(1);

        wr(1'b0, 1'b0, 4'd0, 8'h41);
        expect_push("A_addr", base, 9'h180, acc + 1);
        expect_push("A_data", base + 1, 9'h041, acc + 2);
        chk("A_count", obs_log.size(), base + 2);

        wr(1'b0, 1'b0, 4'd1, 8'h42);
        expect_push("B_data", base, 9'h042, acc + 1);
        chk("B_count", obs_log.size(), base + 1);

        wr(1'b0, 1'b1, 4'd15, 8'h43);
        expect_push("C_addr", base, 9'h1CF, acc + 1);
        expect_push("C_data", base + 1, 9'h043, acc + 2);
        wr(1'b0, 1'b1, 4'd0, 8'h44);
        expect_push("D_addr", base, 9'h1C0, acc + 1);
        expect_push("D_data", base + 1, 9'h044, acc + 2);

        base = obs_log.size();
        drive(1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1);
        acc = acc_cyc;
        repeat (4) drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
        chk("clr_stall", obs_log.size(), base);
        idle_n(4);
        expect_push("clr_push", base, 9'h101, acc + 5);
        chk("clr_count", obs_log.size(), base + 1);

        wr(1'b0, 1'b0, 4'd0, 8'h58);
        expect_push("X_data", base, 9'h058, acc + 1);
        chk("X_count", obs_log.size(), base + 1);

        base = obs_log.size();
        drive(1'b1, 1'b0, 1'b1, 4'd5, 8'h59, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
        @(negedge clk); rst = 1'b0; #3;
        chk("rst_mid_en", en, 0);
        chk("rst_mid_data", data, 0);
        idle_n(2);
        @(negedge clk); rst = 1'b1; buf_full = 1'b0; #3;
        idle_n(3);
        chk("abort_count", obs_log.size(), base);
        wr(1'b0, 1'b0, 4'd1, 8'h5A);
        expect_push("Z_addr", base, 9'h181, acc + 1);
        expect_push("Z_data", base + 1, 9'h05A, acc + 2);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 399) != 0);
            req_valid = $urandom_range(0, 1);
            req_clr   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) begin
                req_row = m_row;
                req_col = 4'(m_col);
            end else begin
                req_row = $urandom_range(0, 1);
                req_col = 4'($urandom_range(0, 15));
            end
            req_char = 8'($urandom);
            buf_full = ($urandom_range(0, 9) < 3);
            #3;
        end
        @(negedge clk); rst = 1'b1; #3;
        idle_n(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
